// File: rtl/adder_share_arb_if.sv
// Requester and adder-side bundle for adder_share_arb.
// slave is the arbiter's view; master is the requesters plus the adder.
interface adder_share_arb_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_REQ  = 4
);
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       add_a;
    logic [DATA_W-1:0]       add_b;
    logic                    add_valid;
    logic                    add_ready;
    logic [DATA_W:0]         add_res;
    logic                    add_res_valid;
    logic [DATA_W:0]         rsp_data;
    logic [N_REQ-1:0]        rsp_valid;

    modport slave (
        input  req_a, req_b, req_valid, add_ready, add_res, add_res_valid,
        output req_ready, add_a, add_b, add_valid, rsp_data, rsp_valid
    );

    modport master (
        output req_a, req_b, req_valid, add_ready, add_res, add_res_valid,
        input  req_ready, add_a, add_b, add_valid, rsp_data, rsp_valid
    );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin sharing of one adder among N_REQ requesters; a tag FIFO of issuer
// indices routes the in-order adder results back to their requesters.
module adder_share_arb #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    adder_share_arb_if.slave             bus,
    output logic [$clog2(TAG_DEPTH):0]   outstanding_o,
    output logic                         err_orphan_o
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned SumW = IdxW + 1;
    localparam int unsigned PtrW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_W-1:0] req_a_arr [N_REQ];
    logic [DATA_W-1:0] req_b_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_a_arr[i] = bus.req_a[i*DATA_W +: DATA_W];
        assign req_b_arr[i] = bus.req_b[i*DATA_W +: DATA_W];
    end

    logic [IdxW-1:0]   rr_q, rr_d;
    logic              add_valid_q, add_valid_d;
    logic [DATA_W-1:0] add_a_q, add_a_d;
    logic [DATA_W-1:0] add_b_q, add_b_d;
    logic [IdxW-1:0]   add_tag_q, add_tag_d;
    logic [CntW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   outstanding_q, outstanding_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W:0]   rsp_data_q, rsp_data_d;
    logic              err_orphan_q, err_orphan_d;
    logic [IdxW-1:0]   tag_mem [TAG_DEPTH];

    logic              grant_found;
    logic [IdxW-1:0]   grant_idx;
    logic [SumW-1:0]   scan_sum;
    logic              can_load;
    logic              load;
    logic [N_REQ-1:0]  req_ready;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              orphan;
    logic [IdxW-1:0]   tag_head;

    // Round-robin scan starting at rr_q, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_q} + SumW'(k);
            if (scan_sum >= SumW'(N_REQ)) begin
                scan_sum = scan_sum - SumW'(N_REQ);
            end
            if (!grant_found && bus.req_valid[scan_sum[IdxW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[IdxW-1:0];
            end
        end
    end

    // rst_n gates the combinational grant so req_ready reads 0 while in reset.
    assign can_load = (!add_valid_q || bus.add_ready) && (outstanding_q < CntW'(TAG_DEPTH));
    assign load     = rst_n && can_load && grant_found;

    always_comb begin
        req_ready = '0;
        if (load) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign push       = add_valid_q && bus.add_ready;
    assign pop        = bus.add_res_valid && !fifo_empty;
    assign orphan     = bus.add_res_valid && fifo_empty;
    assign tag_head   = tag_mem[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        rr_d        = rr_q;
        add_valid_d = add_valid_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_tag_d   = add_tag_q;
        if (load) begin
            rr_d        = (grant_idx == IdxW'(N_REQ - 1)) ? '0 : grant_idx + IdxW'(1);
            add_valid_d = 1'b1;
            add_a_d     = req_a_arr[grant_idx];
            add_b_d     = req_b_arr[grant_idx];
            add_tag_d   = grant_idx;
        end else if (bus.add_ready) begin
            add_valid_d = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q + CntW'(push);
        rd_ptr_d      = rd_ptr_q + CntW'(pop);
        outstanding_d = outstanding_q + CntW'(load) - CntW'(pop);
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        err_orphan_d  = err_orphan_q | orphan;
        if (pop) begin
            rsp_valid_d[tag_head] = 1'b1;
            rsp_data_d            = bus.add_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q          <= '0;
            add_valid_q   <= 1'b0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            add_tag_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            err_orphan_q  <= 1'b0;
        end else begin
            rr_q          <= rr_d;
            add_valid_q   <= add_valid_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            add_tag_q     <= add_tag_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    // Entries are only read while the pointers say they are occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q[PtrW-1:0]] <= add_tag_q;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_valid = add_valid_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign outstanding_o = outstanding_q;
    assign err_orphan_o  = err_orphan_q;

endmodule
